// File: rtl/codemem_readback.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : codemem_readback
// Purpose  : Host read-back path for 64-bit code memory words through a
//            high/low 32-bit register pair. An address strobe starts a fetch.
//            The returned word is held as two 32-bit halves. A host read of
//            the low half steps to the next word and fetches it.
// Ports    : clk, rst_n                  - clock, async active-low reset
//            code_mem_rd_addr/_rd_en     - read request to code memory
//            code_mem_rd_data            - read data, MEM_LATENCY after rd_en
//            readback_addr_value/_strobe - host start address and load strobe
//            inst_high_value/_strobe     - held word [63:32], host read
//            inst_low_value/_strobe      - held word [31:0], host read (advances)
//            readback_valid              - held halves match readback_addr
//            readback_addr               - address being fetched or held
//            control_start               - abort, return to address 0
// Revision : 1.0 - initial release
// ============================================================================
module codemem_readback #(
  parameter int ADDR_WIDTH  = 10,
  parameter int MEM_LATENCY = 1   // legal range 1..4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] code_mem_rd_addr,
  output logic                  code_mem_rd_en,
  input  logic [63:0]           code_mem_rd_data,
  input  logic [31:0]           readback_addr_value,
  input  logic                  readback_addr_strobe,
  output logic [31:0]           inst_high_value,
  input  logic                  inst_high_strobe,
  output logic [31:0]           inst_low_value,
  input  logic                  inst_low_strobe,
  output logic                  readback_valid,
  output logic [ADDR_WIDTH-1:0] readback_addr,
  input  logic                  control_start
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic                  rd_en_q, rd_en_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [31:0]           high_q,  high_d;
  logic [31:0]           low_q,   low_d;

  // A high-half read has no side effect, and address bits above
  // ADDR_WIDTH are ignored; both are consumed here only to keep them visible.
  logic unused_inputs;
  generate
    if (ADDR_WIDTH < 32) begin : g_unused_hi
      assign unused_inputs = ^{inst_high_strobe, readback_addr_value[31:ADDR_WIDTH]};
    end else begin : g_unused_none
      assign unused_inputs = inst_high_strobe;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    high_d  = high_q;
    low_d   = low_q;
    rd_en_d = 1'b0;   // read request is a single-cycle pulse

    if (control_start) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      cnt_d   = '0;
      high_d  = '0;
      low_d   = '0;
    end else if (readback_addr_strobe) begin
      // Legal from any state; in FETCH this abandons the outstanding read
      // because the counter restarts against the new request.
      state_d = ST_FETCH;
      addr_d  = readback_addr_value[ADDR_WIDTH-1:0];
      cnt_d   = CNT_LOAD;
      rd_en_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_FETCH: begin
          // Counter is loaded with MEM_LATENCY on the request edge, so the
          // capture lands MEM_LATENCY+1 edges after the strobe.
          if (cnt_q == '0) begin
            high_d  = code_mem_rd_data[63:32];
            low_d   = code_mem_rd_data[31:0];
            state_d = ST_HOLD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_HOLD: begin
          if (inst_low_strobe) begin
            addr_d  = addr_q + 1'b1;   // natural wrap at 2**ADDR_WIDTH
            state_d = ST_FETCH;
            cnt_d   = CNT_LOAD;
            rd_en_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      cnt_q   <= '0;
      high_q  <= '0;
      low_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
      cnt_q   <= cnt_d;
      high_q  <= high_d;
      low_q   <= low_d;
    end
  end

  assign code_mem_rd_addr = addr_q;
  assign code_mem_rd_en   = rd_en_q;
  assign readback_addr    = addr_q;
  assign readback_valid   = (state_q == ST_HOLD);
  assign inst_high_value  = high_q;
  assign inst_low_value   = low_q;

endmodule
`default_nettype wire
